// File: rtl/hdmi_clk_switch_seq_pkg.sv
// hdmi_clk_switch_seq_pkg: state encoding and default timing constants
// for the HDMI pixel-clock switch sequencer (60 MHz system clock).
package hdmi_clk_switch_seq_pkg;

  localparam logic [2:0] ENC_OFF    = 3'd0;
  localparam logic [2:0] ENC_SEL    = 3'd1;
  localparam logic [2:0] ENC_SETTLE = 3'd2;
  localparam logic [2:0] ENC_LOCK   = 3'd3;
  localparam logic [2:0] ENC_ENA    = 3'd4;
  localparam logic [2:0] ENC_RUN    = 3'd5;
  localparam logic [2:0] ENC_DIS    = 3'd6;

  typedef enum logic [2:0] {
    S_OFF    = ENC_OFF,
    S_SEL    = ENC_SEL,
    S_SETTLE = ENC_SETTLE,
    S_LOCK   = ENC_LOCK,
    S_ENA    = ENC_ENA,
    S_RUN    = ENC_RUN,
    S_DIS    = ENC_DIS
  } state_t;

  // 60 MHz: 16 cyc ~ 267 ns, 4000 cyc ~ 67 us, 64 cyc ~ 1.07 us
  localparam int DEF_CNT_W        = 12;
  localparam int DEF_DIS_WAIT     = 16;
  localparam int DEF_LOCK_TIMEOUT = 4000;
  localparam int DEF_RST_HOLD     = 64;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hdmi_clk_switch_seq_hk_wait_counter.sv
// hk_wait_counter: loadable down-counter that stops at zero.
// Ports: clk, rst_n, load, load_val, dec, cnt, zero.
module hk_wait_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/register_sync.sv
// register_sync: 2-FF synchroniser for a bundle of async inputs.
// Ports: clk, rst_n (async low), d (async in), q (synchronised out).
module register_sync #(
  parameter int                   reg_width  = 3,
  parameter logic [reg_width-1:0] reg_preset = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [reg_width-1:0] d,
  output logic [reg_width-1:0] q
);

  logic [reg_width-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= reg_preset;
      q    <= reg_preset;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hdmi_clk_switch_seq.sv
// hdmi_clk_switch_seq: sequences pixel-clock mux enable/select and the
// HDMI-domain reset request. Ports: clk, nrst, clk_sel_req_i, cfg_done_i,
// src_locked_i (async ins); clk_ena_o, clk_sel_o, hdmi_nrst_o, busy_o,
// timeout_o. Macro HDMI_CLK_SWITCH_STATS_EN adds switch_cnt_o and
// last_lock_cycles_o.
module hdmi_clk_switch_seq
  import hdmi_clk_switch_seq_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DIS_WAIT     = DEF_DIS_WAIT,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int RST_HOLD     = DEF_RST_HOLD
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clk_sel_req_i,
  input  logic             cfg_done_i,
  input  logic             src_locked_i,
  output logic             clk_ena_o,
  output logic             clk_sel_o,
  output logic             hdmi_nrst_o,
  output logic             busy_o,
  output logic             timeout_o
`ifdef HDMI_CLK_SWITCH_STATS_EN
  ,
  output logic [7:0]       switch_cnt_o,
  output logic [CNT_W-1:0] last_lock_cycles_o
`endif
);

  if (DIS_WAIT < 1 || DIS_WAIT > 2**CNT_W) begin : g_bad_dis
    $error("DIS_WAIT out of range for CNT_W");
  end
  if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 2**CNT_W) begin : g_bad_lock
    $error("LOCK_TIMEOUT out of range for CNT_W");
  end
  if (RST_HOLD < 1 || RST_HOLD > 2**CNT_W) begin : g_bad_hold
    $error("RST_HOLD out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LD_DIS  = CNT_W'(DIS_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_LOCK = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(RST_HOLD - 1);

  logic [2:0] sync_q;
  logic       sel_req_s;
  logic       cfg_done_s;
  logic       src_locked_s;

  register_sync #(
    .reg_width (3),
    .reg_preset(3'b000)
  ) u_sync (
    .clk  (clk),
    .rst_n(nrst),
    .d    ({clk_sel_req_i, cfg_done_i, src_locked_i}),
    .q    (sync_q)
  );

  assign {sel_req_s, cfg_done_s, src_locked_s} = sync_q;

  state_t           state;
  state_t           state_n;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  hk_wait_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (nrst),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  logic ena_n;
  logic sel_n;
  logic hnrst_n;
  logic busy_n;
  logic tmo_n;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_OFF;
      clk_ena_o   <= 1'b0;
      clk_sel_o   <= 1'b0;
      hdmi_nrst_o <= 1'b0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state       <= state_n;
      clk_ena_o   <= ena_n;
      clk_sel_o   <= sel_n;
      hdmi_nrst_o <= hnrst_n;
      busy_o      <= busy_n;
      timeout_o   <= tmo_n;
    end
  end

  always_comb begin
    state_n  = state;
    ena_n    = clk_ena_o;
    sel_n    = clk_sel_o;
    hnrst_n  = hdmi_nrst_o;
    tmo_n    = timeout_o;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state)
      S_OFF: begin
        ena_n   = 1'b0;
        hnrst_n = 1'b0;
        if (cfg_done_s) state_n = S_SEL;
      end
      S_SEL: begin
        sel_n    = sel_req_s;
        cnt_load = 1'b1;
        cnt_val  = LD_DIS;
        state_n  = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = LD_LOCK;
          state_n  = S_LOCK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_LOCK: begin
        if (src_locked_s) begin
          cnt_load = 1'b1;
          cnt_val  = LD_HOLD;
          ena_n    = 1'b1;
          state_n  = S_ENA;
        end else if (cnt_zero) begin
          tmo_n   = 1'b1;
          state_n = S_SEL;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_ENA: begin
        if (!src_locked_s) begin
          cnt_load = 1'b1;
          cnt_val  = LD_DIS;
          state_n  = S_DIS;
        end else if (cnt_zero) begin
          hnrst_n = 1'b1;
          state_n = S_RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_RUN: begin
        if (sel_req_s != clk_sel_o
            || !cfg_done_s
            || !src_locked_s) begin
          // reset drops now; enable follows one cycle later
          hnrst_n  = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = LD_DIS;
          state_n  = S_DIS;
        end
      end
      S_DIS: begin
        ena_n   = 1'b0;
        hnrst_n = 1'b0;
        if (cnt_zero) begin
          state_n = cfg_done_s ? S_SEL : S_OFF;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        ena_n   = 1'b0;
        hnrst_n = 1'b0;
        state_n = S_OFF;
      end
    endcase
    busy_n = !(state_n == S_OFF || state_n == S_RUN);
  end

`ifdef HDMI_CLK_SWITCH_STATS_EN
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      switch_cnt_o       <= '0;
      last_lock_cycles_o <= '0;
    end else begin
      if (state == S_ENA && state_n == S_RUN) begin
        switch_cnt_o <= sat_inc8(switch_cnt_o);
      end
      // counter started at LOCK_TIMEOUT-1 on LOCK entry
      if (state == S_LOCK && src_locked_s) begin
        last_lock_cycles_o <= LD_LOCK - cnt + ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_clk_switch_seq.sv
// tb_hdmi_clk_switch_seq: directed/randomised bench with an event-time
// model of the clock-switch sequence.
module tb_hdmi_clk_switch_seq;

  localparam int CW   = 12;
  localparam int DW   = 16;
  localparam int LT   = 100;
  localparam int RH   = 64;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic req = 1'b0;
  logic cfg = 1'b0;
  logic lock = 1'b0;
  logic ena, sel, hn, busy, tmo;
`ifdef HDMI_CLK_SWITCH_STATS_EN
  logic [7:0]    swc;
  logic [CW-1:0] llc;
`endif

  int cyc = 0;
  int nchk = 0;
  int npass = 0;
  int runs = 0;

  always #5 clk = ~clk;

  hdmi_clk_switch_seq #(
    .CNT_W       (CW),
    .DIS_WAIT    (DW),
    .LOCK_TIMEOUT(LT),
    .RST_HOLD    (RH)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .clk_sel_req_i(req),
    .cfg_done_i   (cfg),
    .src_locked_i (lock),
    .clk_ena_o    (ena),
    .clk_sel_o    (sel),
    .hdmi_nrst_o  (hn),
    .busy_o       (busy),
    .timeout_o    (tmo)
`ifdef HDMI_CLK_SWITCH_STATS_EN
    ,
    .switch_cnt_o      (swc),
    .last_lock_cycles_o(llc)
`endif
  );

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    nchk++;
    assert (o === e) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  // s: edge entering SEL; m: edge after which lock input is high;
  // xs: request value sampled in SEL.
  task automatic bring_up(input string tag, input int s,
                          input int m, input logic xs);
    int l, e;
    l = s + 1 + DW;
    e = (m + SYNC + 1 > l + 1) ? m + SYNC + 1 : l + 1;
    goto(s);
    chk({tag, "_sel_busy"}, busy, 1);
    chk({tag, "_sel_ena"}, ena, 0);
    if (m > cyc) goto(m);
    lock = 1'b1;
    goto(e - 1);
    chk({tag, "_pre_ena"}, ena, 0);
    chk({tag, "_pre_busy"}, busy, 1);
    goto(e);
    chk({tag, "_ena"}, ena, 1);
    chk({tag, "_clksel"}, sel, xs);
    chk({tag, "_hn_held"}, hn, 0);
`ifdef HDMI_CLK_SWITCH_STATS_EN
    chk({tag, "_lockcyc"}, llc, e - l);
`endif
    goto(e + RH - 1);
    chk({tag, "_hn_pre"}, hn, 0);
    goto(e + RH);
    runs++;
    chk({tag, "_hn_rel"}, hn, 1);
    chk({tag, "_run_busy"}, busy, 0);
`ifdef HDMI_CLK_SWITCH_STATS_EN
    chk({tag, "_swcnt"}, swc, runs > 255 ? 255 : runs);
`endif
  endtask

  initial begin
    int k, r, s, m, l1, e, n;
    logic cur, f;

    req = 1'($urandom_range(0, 1));
    cfg = 1'b1;
    lock = 1'b1;
    repeat (3) tick();
    chk("rst_ena", ena, 0);
    chk("rst_sel", sel, 0);
    chk("rst_hn", hn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", tmo, 0);

    nrst = 1'b1;
    r = cyc;
    bring_up("pwr", r + SYNC + 1, r, req);

    // select change with random request chatter during DIS
    cur = req;
    goto(cyc + 5);
    k = cyc;
    req = ~cur;
    goto(k + 2);
    chk("sw_hn_still", hn, 1);
    goto(k + 3);
    chk("sw_hn_lo", hn, 0);
    chk("sw_ena_still", ena, 1);
    chk("sw_busy", busy, 1);
    goto(k + 4);
    chk("sw_ena_lo", ena, 0);
    lock = 1'b0;
    n = int'($urandom_range(1, 5));
    for (int i = 0; i < n; i++) begin
      tick();
      req = 1'($urandom_range(0, 1));
    end
    f = req;
    s = k + 3 + DW;
    goto(s);
    chk("sw_sel_old", sel, cur);
    m = s + 1 + DW + int'($urandom_range(0, 40));
    bring_up("sw", s, m, f);

    // lock timeout then late lock
    cur = req;
    goto(cyc + 5);
    k = cyc;
    lock = 1'b0;
    goto(k + 3);
    chk("to_hn_lo", hn, 0);
    l1 = k + 3 + DW + 1 + DW;
    goto(l1 + LT - 1);
    chk("to_pre", tmo, 0);
    chk("to_pre_ena", ena, 0);
    goto(l1 + LT);
    chk("to_flag", tmo, 1);
    chk("to_busy", busy, 1);
    s = l1 + LT;
    m = s + int'($urandom_range(0, 40));
    bring_up("to", s, m, cur);
    chk("to_sticky", tmo, 1);

    // simultaneous select change and cfg_done drop
    cur = req;
    goto(cyc + 5);
    k = cyc;
    cfg = 1'b0;
    req = ~cur;
    goto(k + 3);
    chk("cfg_hn_lo", hn, 0);
    chk("cfg_ena_hold", ena, 1);
    goto(k + 4);
    chk("cfg_ena_lo", ena, 0);
    goto(k + 3 + DW - 1);
    chk("cfg_dis_busy", busy, 1);
    goto(k + 3 + DW);
    chk("cfg_off_busy", busy, 0);
    chk("cfg_off_ena", ena, 0);
    chk("cfg_off_hn", hn, 0);
    chk("cfg_off_sel", sel, cur);
    goto(cyc + 6);
    cfg = 1'b1;
    r = cyc;
    bring_up("cfg", r + SYNC + 1, r, req);

    // async reset while in ENA
    cur = req;
    goto(cyc + 5);
    k = cyc;
    req = ~cur;
    e = k + 3 + DW + 1 + DW + 1;
    goto(e + 10);
    chk("ar_in_ena", ena, 1);
    #3;
    nrst = 1'b0;
    #1;
    chk("ar_ena", ena, 0);
    chk("ar_sel", sel, 0);
    chk("ar_hn", hn, 0);
    chk("ar_busy", busy, 0);
    chk("ar_tmo", tmo, 0);
    tick();
    tick();
    nrst = 1'b1;
    runs = 0;
    r = cyc;
    bring_up("ar", r + SYNC + 1, r, req);
    chk("ar_tmo_clr", tmo, 0);

`ifdef HDMI_CLK_SWITCH_STATS_EN
    for (int i = 0; i < 300; i++) begin
      cur = req;
      goto(cyc + 2);
      k = cyc;
      req = ~cur;
      bring_up("sat", k + 3 + DW, k, req);
    end
    chk("sat_final", swc, 255);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
